// File: rtl/gate_sweep_if.sv
// Handshake and gate-drive bundle between the sweep controller
// and its supervisor / gate under control.
interface gate_sweep_if #(
    parameter int N_IN = 2
);
    localparam int W = 1 << N_IN;

    logic            start;
    logic            abort;
    logic            gate_y;
    logic [N_IN-1:0] gate_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [W-1:0]    truth;
    logic [N_IN:0]   mismatches;

    modport master (
        output start,
        output abort,
        output gate_y,
        input  gate_in,
        input  busy,
        input  done,
        input  pass,
        input  truth,
        input  mismatches
    );

    modport slave (
        input  start,
        input  abort,
        input  gate_y,
        output gate_in,
        output busy,
        output done,
        output pass,
        output truth,
        output mismatches
    );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sweeper for an N-input combinational gate.
// Steps every input vector, settles, samples, then grades the table.
module gate_sweep_ctrl #(
    parameter int                   N_IN       = 2,
    parameter int                   SETTLE_CYC = 2,
    parameter logic [(1<<N_IN)-1:0] EXPECTED   = 4'b1001
) (
    input  logic         clk,
    input  logic         rst_n,
    gate_sweep_if.slave  bus
);
    localparam int W  = 1 << N_IN;
    localparam int CW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;

    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [N_IN-1:0] gate_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [W-1:0]    truth;
    logic [N_IN:0]   mismatches;

    function automatic logic [N_IN:0] popcnt(input logic [W-1:0] v);
        logic [N_IN:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            c = c + {{N_IN{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [W-1:0] diff;
    assign diff = truth ^ EXPECTED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            gate_in    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            truth      <= '0;
            mismatches <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    // abort beats start; results stay visible until accepted
                    if (bus.start && !bus.abort) begin
                        state      <= S_SETTLE;
                        gate_in    <= '0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        truth      <= '0;
                        mismatches <= '0;
                    end
                end
                S_SETTLE: begin
                    if (bus.abort) begin
                        state   <= S_IDLE;
                        gate_in <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        truth[gate_in] <= bus.gate_y;
                        if (gate_in == VEC_LAST) begin
                            state <= S_CHECK;
                        end else begin
                            gate_in <= gate_in + 1'b1;
                            cnt     <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    pass       <= (truth == EXPECTED);
                    mismatches <= popcnt(diff);
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    gate_in    <= '0;
                    state      <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    gate_in <= '0;
                end
            endcase
        end
    end

    assign bus.gate_in    = gate_in;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.pass       = pass;
    assign bus.truth      = truth;
    assign bus.mismatches = mismatches;
endmodule
